// File: rtl/scr1_dmem_wbuf.sv
// +--------------------------------------------------------------------------+
// | scr1_dmem_wbuf : posted-store write buffer between the LSU and DMEM.     |
// | Optional sticky store-error capture: define SCR1_DMEM_WBUF_ERR_EN.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module scr1_dmem_wbuf #(
    parameter int WBUF_DEPTH = 2,
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu2wbuf_req_i,
    input  logic              lsu2wbuf_cmd_i,
    input  logic [1:0]        lsu2wbuf_width_i,
    input  logic [AWIDTH-1:0] lsu2wbuf_addr_i,
    input  logic [DWIDTH-1:0] lsu2wbuf_wdata_i,
    output logic              wbuf2lsu_req_ack_o,
    output logic [DWIDTH-1:0] wbuf2lsu_rdata_o,
    output logic [1:0]        wbuf2lsu_resp_o,
    output logic              wbuf2mem_req_o,
    output logic              wbuf2mem_cmd_o,
    output logic [1:0]        wbuf2mem_width_o,
    output logic [AWIDTH-1:0] wbuf2mem_addr_o,
    output logic [DWIDTH-1:0] wbuf2mem_wdata_o,
    input  logic              mem2wbuf_req_ack_i,
    input  logic [DWIDTH-1:0] mem2wbuf_rdata_i,
    input  logic [1:0]        mem2wbuf_resp_i,
`ifdef SCR1_DMEM_WBUF_ERR_EN
    output logic              wbuf_err_o,
    output logic [AWIDTH-1:0] wbuf_err_addr_o,
    input  logic              wbuf_err_clr_i,
`endif
    output logic              wbuf_empty_o
);

    localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WBUF_DEPTH);
    localparam logic [1:0]    RESP_OK  = 2'd1;
    localparam logic [1:0]    RESP_ER  = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ST_WAIT = 2'd1,
        LD_WAIT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              st_ok_q;
    logic [AWIDTH-1:0] addr_q  [WBUF_DEPTH];
    logic [1:0]        width_q [WBUF_DEPTH];
    logic [DWIDTH-1:0] wdata_q [WBUF_DEPTH];

    logic w_full, w_resp_vld, w_push, w_pop, w_ld_go, w_drain;

    // Request-side strobes are masked by rst so every output is 0 during reset.
    assign w_full     = (cnt_q == CNT_FULL);
    assign w_resp_vld = (mem2wbuf_resp_i == RESP_OK) || (mem2wbuf_resp_i == RESP_ER);
    assign w_push     = ~rst & lsu2wbuf_req_i & lsu2wbuf_cmd_i & ~w_full & (state_q != LD_WAIT);
    assign w_ld_go    = ~rst & lsu2wbuf_req_i & ~lsu2wbuf_cmd_i & (cnt_q == '0)
                        & (state_q == IDLE) & ~w_push;
    assign w_drain    = ~rst & (state_q == IDLE) & (cnt_q != '0);
    assign w_pop      = (state_q == ST_WAIT) & w_resp_vld;

    always_comb begin
        cnt_d = cnt_q;
        case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (w_drain && mem2wbuf_req_ack_i)
                    state_d = ST_WAIT;
                else if (w_ld_go && mem2wbuf_req_ack_i)
                    state_d = LD_WAIT;
            end
            ST_WAIT: if (w_resp_vld) state_d = IDLE;
            LD_WAIT: if (w_resp_vld) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            st_ok_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_ok_q <= w_push;
            if (w_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            addr_q[wr_ptr_q]  <= lsu2wbuf_addr_i;
            width_q[wr_ptr_q] <= lsu2wbuf_width_i;
            wdata_q[wr_ptr_q] <= lsu2wbuf_wdata_i;
        end
    end

    // Drain of buffered stores takes precedence over a waiting load.
    always_comb begin
        wbuf2mem_req_o   = 1'b0;
        wbuf2mem_cmd_o   = 1'b0;
        wbuf2mem_width_o = '0;
        wbuf2mem_addr_o  = '0;
        wbuf2mem_wdata_o = '0;
        if (w_drain) begin
            wbuf2mem_req_o   = 1'b1;
            wbuf2mem_cmd_o   = 1'b1;
            wbuf2mem_width_o = width_q[rd_ptr_q];
            wbuf2mem_addr_o  = addr_q[rd_ptr_q];
            wbuf2mem_wdata_o = wdata_q[rd_ptr_q];
        end else if (w_ld_go) begin
            wbuf2mem_req_o   = 1'b1;
            wbuf2mem_width_o = lsu2wbuf_width_i;
            wbuf2mem_addr_o  = lsu2wbuf_addr_i;
            wbuf2mem_wdata_o = lsu2wbuf_wdata_i;
        end
    end

    always_comb begin
        wbuf2lsu_req_ack_o = w_push | (w_ld_go & mem2wbuf_req_ack_i);
        wbuf2lsu_resp_o    = 2'd0;
        wbuf2lsu_rdata_o   = '0;
        if (state_q == LD_WAIT) begin
            wbuf2lsu_resp_o  = mem2wbuf_resp_i;
            wbuf2lsu_rdata_o = mem2wbuf_rdata_i;
        end else if (st_ok_q) begin
            wbuf2lsu_resp_o = RESP_OK;
        end
    end

    assign wbuf_empty_o = (cnt_q == '0) && (state_q == IDLE);

`ifdef SCR1_DMEM_WBUF_ERR_EN
    logic              err_q;
    logic [AWIDTH-1:0] err_addr_q;
    logic              w_err_set;

    assign w_err_set = w_pop & (mem2wbuf_resp_i == RESP_ER);

    // A new error beats a simultaneous clear and becomes the captured one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else if (w_err_set) begin
            err_q <= 1'b1;
            if (!err_q || wbuf_err_clr_i) err_addr_q <= addr_q[rd_ptr_q];
        end else if (wbuf_err_clr_i) begin
            err_q <= 1'b0;
        end
    end

    assign wbuf_err_o      = err_q;
    assign wbuf_err_addr_o = err_addr_q;
`endif

endmodule

`default_nettype wire

// File: doc/scr1_dmem_wbuf.md
Name: scr1_dmem_wbuf

Overview:
Posted-store write buffer sitting directly downstream of the pipeline LSU, between the LSU DMEM port and the DMEM router/bridge.
- Stores are acknowledged immediately, answered RDY_OK one cycle later, and drained to memory in order.
- Loads wait until the buffer is empty, then pass through.
- Reported store errors are imprecise: they are captured in a sticky status register.

Parameters:
- WBUF_DEPTH, 2, number of store entries; power of two, at least 2.
- AWIDTH, 32, DMEM address width.
- DWIDTH, 32, DMEM data width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- lsu2wbuf_req_i  in  1  upstream request
- lsu2wbuf_cmd_i  in  1  0=RD, 1=WR
- lsu2wbuf_width_i  in  2  0=BYTE, 1=HWORD, 2=WORD
- lsu2wbuf_addr_i  in  AWIDTH  address
- lsu2wbuf_wdata_i  in  DWIDTH  store data
- wbuf2lsu_req_ack_o  out  1  request accepted
- wbuf2lsu_rdata_o  out  DWIDTH  load data
- wbuf2lsu_resp_o  out  2  0=IDLE, 1=RDY_OK, 2=RDY_ER
- wbuf2mem_req_o  out  1  downstream request
- wbuf2mem_cmd_o  out  1  downstream command
- wbuf2mem_width_o  out  2  downstream width
- wbuf2mem_addr_o  out  AWIDTH  downstream address
- wbuf2mem_wdata_o  out  DWIDTH  downstream write data
- mem2wbuf_req_ack_i  in  1  downstream accept
- mem2wbuf_rdata_i  in  DWIDTH  downstream read data
- mem2wbuf_resp_i  in  2  downstream response
- wbuf_empty_o  out  1  buffer empty and drain FSM IDLE (for FENCE)

Behaviour:
Reset:
- One clock `clk`; reset `rst` is asynchronous and active-high.
- While `rst` is high: FIFO pointers and count are 0, FSM is IDLE, store-response flag is 0, all outputs are 0, `wbuf_empty_o`=1, `wbuf2lsu_resp_o`=IDLE.
- Reset mid-operation discards all entries and outstanding transactions, with no downstream response tracking.

FIFO:
- Entry = {addr, width, wdata}.
- Separate wrapping read/write pointers plus a count of width log2(WBUF_DEPTH)+1.
- full = (count == WBUF_DEPTH).

Store accept:
- Condition: req & cmd=WR & ~full & FSM != LD_WAIT.
- Effect: `wbuf2lsu_req_ack_o`=1 in the same cycle and the entry is pushed.
- Next cycle: `wbuf2lsu_resp_o`=RDY_OK for exactly 1 cycle.
- When full, the ack is withheld even if a pop happens in the same cycle; the store is accepted one cycle later.

Load accept:
- Condition: req & cmd=RD & count==0 & FSM==IDLE & no push this cycle.
- Path is combinational: `wbuf2mem_req_o`=1 with the upstream fields, and `wbuf2lsu_req_ack_o`=`mem2wbuf_req_ack_i`.
- Downstream ack moves FSM IDLE -> LD_WAIT.

Drain FSM (IDLE, ST_WAIT, LD_WAIT):
- IDLE, count>0: present the head store to memory (cmd=WR, head fields). The request is held stable until acked. On ack -> ST_WAIT. Drain has priority over a pending load.
- ST_WAIT: on RDY_OK or RDY_ER, pop the head -> IDLE. RDY_ER handling is defined under Optional Feature. Nothing is sent upstream in either case.
- LD_WAIT: `wbuf2lsu_resp_o`=`mem2wbuf_resp_i` and `wbuf2lsu_rdata_o`=`mem2wbuf_rdata_i` combinationally. On RDY_OK/RDY_ER -> IDLE.
- Memory is never presented a new request while in ST_WAIT or LD_WAIT.

Other rules:
- `wbuf2lsu_rdata_o`=0 outside LD_WAIT.
- Push and pop in the same cycle leave count unchanged.
- Store order to memory equals acceptance order.
- No data forwarding from buffered stores to loads.
- A downstream response while in IDLE is ignored.

Optional Feature:
Macro: SCR1_DMEM_WBUF_ERR_EN.

Defined:
- Extra ports `wbuf_err_o` (out, 1), `wbuf_err_addr_o` (out, AWIDTH), and `wbuf_err_clr_i` (in, 1).
- In ST_WAIT, RDY_ER sets `wbuf_err_o` and captures the head address. Only the first error is captured until cleared.
- `wbuf_err_clr_i` clears the flag; an error arriving in the same cycle as the clear wins.
- Reset value is 0.

Undefined:
- None of these ports exist; RDY_ER on a drained store is silently dropped.

Test Plan:
1. DEPTH=2, memory acks immediately and responds on the next cycle. SW 0x100=0xDEADBEEF -> ack in the same cycle, upstream RDY_OK 1 cycle later; memory sees WR 0x100 WORD 0xDEADBEEF, and `wbuf_empty_o` returns to 1 after the response.
2. Memory ack stalled. Three back-to-back SBs to 0x10/0x11/0x12 -> first two acked; third acked only in the cycle after the first pop. Memory order is 0x10, 0x11, 0x12.
3. One store pending, then LW 0x200 -> load not acked until the store response pops the buffer. The load is then passed through, and `rdata_o`=`mem2wbuf_rdata_i`=0x12345678 with RDY_OK.
4. LW with downstream RDY_ER -> upstream RDY_ER in the same cycle, FSM returns to IDLE.
5. With SCR1_DMEM_WBUF_ERR_EN: SW 0x300 gets RDY_ER -> upstream saw RDY_OK, `wbuf_err_o`=1, `wbuf_err_addr_o`=0x300. A second error at 0x304 leaves 0x300. Pulsing clear drops `wbuf_err_o` to 0.
6. Assert `rst` while in ST_WAIT with 2 entries -> all outputs are 0 immediately and `wbuf_empty_o`=1. After release, a new SW drains normally.
